// File: rtl/gpio_in_cond_pkg.sv
// gpio_in_cond shared constants.
// Default widths and depths for the GPIO input conditioner.
package gpio_in_cond_pkg;
  localparam int GPIO_W_DEF      = 32;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_SAMPLES_DEF = 3;
  localparam int TS_W            = 32;
endpackage

// File: rtl/gpio_in_deb_bit.sv
// One GPIO bit: synchroniser, tick-sampled debounce history,
// filtered level and registered edge pulses.
module gpio_in_deb_bit
  import gpio_in_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic tick,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_SAMPLES-2:0] hist;
  logic [DEB_SAMPLES-1:0] win;
  logic                   filt_q;

  // The incoming sample is part of the window, so a level is
  // accepted on the same tick its last required sample arrives.
  assign win = {hist, sync[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      hist   <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (tick) begin
        hist <= win[DEB_SAMPLES-2:0];
        if (&win)
          filt <= 1'b1;
        else if (~|win)
          filt <= 1'b0;
      end
      filt_q <= filt;
      rise   <= filt & ~filt_q;
      fall   <= ~filt & filt_q;
    end
  end

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: debounce, edge events, sticky status, irq.
// Optional timestamp capture enabled by GPIO_IN_TIMESTAMP_EN.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int GPIO_W      = GPIO_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic [CNT_W-1:0]  presc,
  input  logic [GPIO_W-1:0] rise_en,
  input  logic [GPIO_W-1:0] fall_en,
  input  logic [GPIO_W-1:0] irq_mask,
  input  logic              clr_valid,
  input  logic [GPIO_W-1:0] clr_mask,
  output logic              clr_ready,
  output logic [GPIO_W-1:0] gpio_filt,
  output logic [GPIO_W-1:0] rise,
  output logic [GPIO_W-1:0] fall,
  output logic [GPIO_W-1:0] evt_status,
  output logic              irq
`ifdef GPIO_IN_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]           evt_ts,
  output logic [$clog2(GPIO_W)-1:0] evt_ts_bit
`endif
);

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [GPIO_W-1:0] set_vec;
  logic [GPIO_W-1:0] clr_vec;

  assign tick = (cnt == presc);

  // Counter wraps on reaching presc, or silently if presc shrank below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cnt >= presc)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < GPIO_W; g++) begin : g_bit
    gpio_in_deb_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_SAMPLES(DEB_SAMPLES)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .din (gpio_in[g]),
      .tick(tick),
      .filt(gpio_filt[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end

  assign set_vec = (rise & rise_en) | (fall & fall_en);
  assign clr_vec = clr_valid ? clr_mask : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_status <= '0;
      clr_ready  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      evt_status <= (evt_status & ~clr_vec) | set_vec;
      clr_ready  <= clr_valid;
      irq        <= |(evt_status & irq_mask);
    end
  end

`ifdef GPIO_IN_TIMESTAMP_EN
  localparam int IW = $clog2(GPIO_W);

  logic [TS_W-1:0] ts_cnt;
  logic [IW-1:0]   low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = GPIO_W - 1; i >= 0; i--)
      if (set_vec[i])
        low_idx = i[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt     <= '0;
      evt_ts     <= '0;
      evt_ts_bit <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (|set_vec) begin
        evt_ts     <= ts_cnt;
        evt_ts_bit <= low_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed self-checking bench for gpio_in_cond.
// Timestamp checks run only when GPIO_IN_TIMESTAMP_EN is defined.
module tb_gpio_in_cond;
  import gpio_in_cond_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [15:0] presc;
  logic [31:0] rise_en;
  logic [31:0] fall_en;
  logic [31:0] irq_mask;
  logic        clr_valid;
  logic [31:0] clr_mask;
  logic        clr_ready;
  logic [31:0] gpio_filt;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] evt_status;
  logic        irq;
`ifdef GPIO_IN_TIMESTAMP_EN
  logic [31:0] evt_ts;
  logic [4:0]  evt_ts_bit;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  gpio_in_cond dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .presc     (presc),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .irq_mask  (irq_mask),
    .clr_valid (clr_valid),
    .clr_mask  (clr_mask),
    .clr_ready (clr_ready),
    .gpio_filt (gpio_filt),
    .rise      (rise),
    .fall      (fall),
    .evt_status(evt_status),
    .irq       (irq)
`ifdef GPIO_IN_TIMESTAMP_EN
    ,
    .evt_ts    (evt_ts),
    .evt_ts_bit(evt_ts_bit)
`endif
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    gpio_in   = '0;
    presc     = '0;
    rise_en   = '0;
    fall_en   = '0;
    irq_mask  = '0;
    clr_valid = 1'b0;
    clr_mask  = '0;
    step(3);
    chk("rst_filt", gpio_filt, 32'h0);
    chk("rst_status", evt_status, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_clr_ready", {31'b0, clr_ready}, 32'h0);
    rst = 1'b0;
    cyc = 0;
    step(2);

    // 1: presc=0 rise on bit 1, exact latency
    rise_en  = 32'h2;
    irq_mask = 32'h2;
    gpio_in[1] = 1'b1;
    step(4);
    chk("t1_filt_at4", gpio_filt, 32'h0);
    step(1);
    chk("t1_filt_at5", gpio_filt, 32'h2);
    chk("t1_rise_pre", rise, 32'h0);
    step(1);
    chk("t1_rise", rise, 32'h2);
    step(1);
    chk("t1_rise_end", rise, 32'h0);
    chk("t1_status", evt_status, 32'h2);
    chk("t1_irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    chk("t1_irq", {31'b0, irq}, 32'h1);

    // 3: rise coincident with clear keeps the flag
    gpio_in[1] = 1'b0;
    step(6);
    chk("t3_fall", gpio_filt, 32'h0);
    chk("t3_no_fall_evt", evt_status, 32'h2);
    gpio_in[1] = 1'b1;
    step(6);
    chk("t3_rise_now", rise, 32'h2);
    clr_valid = 1'b1;
    clr_mask  = 32'h2;
    step(1);
    clr_valid = 1'b0;
    chk("t3_set_wins", evt_status, 32'h2);
    chk("t3_ready", {31'b0, clr_ready}, 32'h1);
    step(1);
    chk("t3_ready_end", {31'b0, clr_ready}, 32'h0);
    clr_valid = 1'b1;
    step(1);
    chk("t3_cleared", evt_status, 32'h0);
    chk("t3_b2b_ready1", {31'b0, clr_ready}, 32'h1);
    step(1);
    clr_valid = 1'b0;
    chk("t3_b2b_ready2", {31'b0, clr_ready}, 32'h1);
    chk("t3_irq_off", {31'b0, irq}, 32'h0);
    step(1);
    chk("t3_ready_idle", {31'b0, clr_ready}, 32'h0);

    // 2: presc=9 glitch rejected, long pulse accepted
    gpio_in[1] = 1'b0;
    step(8);
    chk("t2_base", gpio_filt, 32'h0);
    presc = 16'd9;
    step(3);
    gpio_in[1] = 1'b1;
    step(2);
    gpio_in[1] = 1'b0;
    step(50);
    chk("t2_glitch_filt", gpio_filt, 32'h0);
    chk("t2_glitch_status", evt_status, 32'h0);
    gpio_in[1] = 1'b1;
    step(35);
    gpio_in[1] = 1'b0;
    chk("t2_pulse_filt", gpio_filt, 32'h2);
    chk("t2_pulse_status", evt_status, 32'h2);
    step(40);
    chk("t2_pulse_end", gpio_filt, 32'h0);

    // 4: falling-edge only events on bit 0
    presc     = '0;
    clr_valid = 1'b1;
    clr_mask  = 32'hffff_ffff;
    step(1);
    clr_valid = 1'b0;
    rise_en   = 32'h0;
    fall_en   = 32'h1;
    irq_mask  = 32'h0;
    gpio_in[0] = 1'b1;
    step(8);
    chk("t4_hi_filt", gpio_filt, 32'h1);
    chk("t4_rise_ignored", evt_status, 32'h0);
    gpio_in[0] = 1'b0;
    step(8);
    chk("t4_fall_evt", evt_status, 32'h1);
    chk("t4_irq_masked", {31'b0, irq}, 32'h0);
    gpio_in[0] = 1'b1;
    step(8);
    chk("t4_rise_no_chg", evt_status, 32'h1);
    fall_en = 32'h0;
    step(2);
    chk("t4_pending_kept", evt_status, 32'h1);

    // 5: reset mid-debounce on bit 3
    rise_en = 32'h8;
    gpio_in[3] = 1'b1;
    step(3);
    rst = 1'b1;
    #1;
    chk("t5_rst_filt", gpio_filt, 32'h0);
    chk("t5_rst_status", evt_status, 32'h0);
    chk("t5_rst_rise", rise, 32'h0);
    step(1);
    rst = 1'b0;
    cyc = 0;
    step(4);
    chk("t5_filt_at4", gpio_filt & 32'h8, 32'h0);
    step(1);
    chk("t5_filt_at5", gpio_filt & 32'h8, 32'h8);
    step(1);
    chk("t5_rise", rise & 32'h8, 32'h8);
    step(1);
    chk("t5_status", evt_status, 32'h8);

`ifdef GPIO_IN_TIMESTAMP_EN
    // 6: simultaneous events on bits 5 and 2 at counter 100
    rise_en = 32'h24;
    step(94 - cyc);
    gpio_in[5] = 1'b1;
    gpio_in[2] = 1'b1;
    step(7);
    chk("t6_ts", evt_ts, 32'd100);
    chk("t6_ts_bit", {27'b0, evt_ts_bit}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
